// File: rtl/p_calc_pkg.sv
// rtl/p_calc_pkg.sv - shared types and table geometry for the P_calculator issue scheduler
package p_calc_pkg;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_DRAINED
   } state_t;

   localparam int TABLE_ENTRIES = 6;
   localparam int JOINT_ENTRIES = 18;
   localparam int N_ENTRIES     = 2;
   localparam int PAB_WORDS     = 9;
   localparam int PBC_WORDS     = 6;
   localparam int PCA_WORDS     = 6;
   localparam int RES_WORDS     = PAB_WORDS + PBC_WORDS + PCA_WORDS;

endpackage

// File: rtl/p_calc_scheduler_fifo.sv
// rtl/p_calc_scheduler_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_rdata,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // A push into a full FIFO is allowed only when the head leaves in the same cycle.
   assign w_do_pop  = i_pop && (r_count != '0);
   assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);
   assign o_rdata   = r_mem[r_rptr];
   assign o_count   = r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + AW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_wdata;
   end

endmodule

// File: rtl/p_calc_scheduler.sv
// rtl/p_calc_scheduler.sv - credit-based issue controller tagging jobs for P_calculator
module p_calc_scheduler
   import p_calc_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int P_WIDTH    = 32,
   parameter int ID_WIDTH   = 16,
   parameter int RES_DEPTH  = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                job_valid,
   output logic                                job_ready,
   input  logic [ID_WIDTH-1:0]                 job_pair_id,
   input  logic [TABLE_ENTRIES*DATA_WIDTH-1:0] job_first_margin,
   input  logic [TABLE_ENTRIES*DATA_WIDTH-1:0] job_second_margin,
   input  logic [JOINT_ENTRIES*DATA_WIDTH-1:0] job_joint,
   input  logic [N_ENTRIES*DATA_WIDTH-1:0]     job_n,
   output logic [TABLE_ENTRIES*DATA_WIDTH-1:0] calc_first_margin,
   output logic [TABLE_ENTRIES*DATA_WIDTH-1:0] calc_second_margin,
   output logic [JOINT_ENTRIES*DATA_WIDTH-1:0] calc_joint,
   output logic [N_ENTRIES*DATA_WIDTH-1:0]     calc_n,
   output logic                                calc_data_valid,
   input  logic [PAB_WORDS*P_WIDTH-1:0]        calc_Pab,
   input  logic [PBC_WORDS*P_WIDTH-1:0]        calc_Pbc,
   input  logic [PCA_WORDS*P_WIDTH-1:0]        calc_Pca,
   input  logic                                calc_data_valid_out,
   output logic                                res_valid,
   input  logic                                res_ready,
   output logic [ID_WIDTH-1:0]                 res_pair_id,
   output logic [RES_WORDS*P_WIDTH-1:0]        res_P,
   input  logic                                drain_req,
   output logic                                drain_done,
   output logic [$clog2(RES_DEPTH):0]          inflight,
   output logic                                err_spurious
);

   localparam int CW = $clog2(RES_DEPTH) + 1;
   localparam int PW = RES_WORDS * P_WIDTH;
   localparam int RW = ID_WIDTH + PW;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(RES_DEPTH);

   state_t                              r_state;
   logic                                r_drain_done;
   logic                                r_err;
   logic                                r_calc_dv;
   logic [TABLE_ENTRIES*DATA_WIDTH-1:0] r_first;
   logic [TABLE_ENTRIES*DATA_WIDTH-1:0] r_second;
   logic [JOINT_ENTRIES*DATA_WIDTH-1:0] r_joint;
   logic [N_ENTRIES*DATA_WIDTH-1:0]     r_n;

   logic [CW-1:0]       w_tag_count;
   logic [CW-1:0]       w_res_count;
   logic [CW-1:0]       w_occ;
   logic [ID_WIDTH-1:0] w_tag;
   logic [RW-1:0]       w_res_wdata;
   logic [RW-1:0]       w_res_rdata;
   logic                w_accept;
   logic                w_result;
   logic                w_res_valid;
   logic                w_res_pop;

   // The tag FIFO holds exactly one entry per job in flight, so its count is the in-flight counter.
   assign w_occ       = w_tag_count + w_res_count;
   assign job_ready   = (r_state == ST_RUN) && (w_occ < DEPTH_CNT);
   assign w_accept    = job_valid && job_ready;
   assign w_result    = calc_data_valid_out && (w_tag_count != '0);
   assign w_res_valid = (w_res_count != '0);
   assign w_res_pop   = w_res_valid && res_ready;
   assign w_res_wdata = {w_tag, calc_Pca, calc_Pbc, calc_Pab};

   sync_fifo #(.WIDTH(ID_WIDTH), .DEPTH(RES_DEPTH)) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_accept),
      .i_wdata (job_pair_id),
      .i_pop   (w_result),
      .o_rdata (w_tag),
      .o_count (w_tag_count)
   );

   sync_fifo #(.WIDTH(RW), .DEPTH(RES_DEPTH)) u_res_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_result),
      .i_wdata (w_res_wdata),
      .i_pop   (w_res_pop),
      .o_rdata (w_res_rdata),
      .o_count (w_res_count)
   );

   // Head data is masked while empty so stale buffer contents never reach the host.
   assign res_valid          = w_res_valid;
   assign res_pair_id        = w_res_valid ? w_res_rdata[RW-1 -: ID_WIDTH] : '0;
   assign res_P              = w_res_valid ? w_res_rdata[PW-1:0] : '0;
   assign inflight           = w_tag_count;
   assign drain_done         = r_drain_done;
   assign err_spurious       = r_err;
   assign calc_data_valid    = r_calc_dv;
   assign calc_first_margin  = r_first;
   assign calc_second_margin = r_second;
   assign calc_joint         = r_joint;
   assign calc_n             = r_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_calc_dv <= 1'b0;
         r_first   <= '0;
         r_second  <= '0;
         r_joint   <= '0;
         r_n       <= '0;
         r_err     <= 1'b0;
      end else begin
         r_calc_dv <= w_accept;
         if (w_accept) begin
            r_first  <= job_first_margin;
            r_second <= job_second_margin;
            r_joint  <= job_joint;
            r_n      <= job_n;
         end
         if (calc_data_valid_out && (w_tag_count == '0)) r_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_RUN;
         r_drain_done <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (drain_req) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if ((w_tag_count == '0) && (w_res_count == '0)) begin
                  r_state      <= ST_DRAINED;
                  r_drain_done <= 1'b1;
               end
            end
            ST_DRAINED: begin
               if (!drain_req) begin
                  r_state      <= ST_RUN;
                  r_drain_done <= 1'b0;
               end
            end
            default: begin
               r_state      <= ST_RUN;
               r_drain_done <= 1'b0;
            end
         endcase
      end
   end

endmodule
